// File: rtl/microseq_pkg.sv
// Shared encodings for the microprogram sequencer.
// The encoder uses the same constants, so both sides agree on the fetch and undefined addresses.
package microseq_pkg;

  typedef enum logic [2:0] {
    NS_INC     = 3'b000,
    NS_JUMP    = 3'b001,
    NS_DECODE  = 3'b010,
    NS_COND    = 3'b011,
    NS_WAITMFC = 3'b100,
    NS_FETCH   = 3'b101,
    NS_CALL    = 3'b110,
    NS_RET     = 3'b111
  } nsSel_t;

  typedef enum logic {
    RUN  = 1'b0,
    WAIT = 1'b1
  } seqState_t;

  localparam logic [6:0] DEFAULT_FETCH_ADDR = 7'd1;
  localparam logic [6:0] DEFAULT_UNDEF_CODE = 7'd91;

endpackage

// File: rtl/microseq_nextaddr_mux.sv
// Combinational next-address selector used while the sequencer is in RUN.
// Also exposes the plain increment, which the WAIT path reuses.
module microseq_nextaddr_mux
  import microseq_pkg::*;
#(
  parameter int                ADDR_W     = 7,
  parameter logic [ADDR_W-1:0] FETCH_ADDR = ADDR_W'(DEFAULT_FETCH_ADDR)
) (
  input  logic [ADDR_W-1:0] state,
  input  logic [2:0]        nsSel,
  input  logic [ADDR_W-1:0] crAddr,
  input  logic [ADDR_W-1:0] encoderAddr,
  input  logic              inv,
  input  logic              cond,
  input  logic              mfc,
  input  logic [ADDR_W-1:0] retAddr,
  input  logic              retValid,
  output logic [ADDR_W-1:0] incAddr,
  output logic [ADDR_W-1:0] runAddr
);

  logic condTaken;

  assign incAddr   = state + ADDR_W'(1);
  assign condTaken = cond ^ inv;

  // A WAITMFC without a same-cycle MFC holds the address; the stall itself is handled by the FSM.
  always_comb begin
    runAddr = incAddr;
    case (nsSel)
      NS_INC:     runAddr = incAddr;
      NS_JUMP:    runAddr = crAddr;
      NS_DECODE:  runAddr = encoderAddr;
      NS_COND:    runAddr = condTaken ? crAddr : incAddr;
      NS_WAITMFC: runAddr = mfc ? incAddr : state;
      NS_FETCH:   runAddr = FETCH_ADDR;
      NS_CALL:    runAddr = crAddr;
      NS_RET:     runAddr = retValid ? retAddr : FETCH_ADDR;
      default:    runAddr = incAddr;
    endcase
  end

endmodule

// File: rtl/microseq_controller.sv
// Microprogram sequencer: holds the control-store address, the RUN/WAIT stall FSM,
// the MFC timeout counter and a single-level return register.
module microseq_controller
  import microseq_pkg::*;
#(
  parameter int                ADDR_W      = 7,
  parameter logic [ADDR_W-1:0] FETCH_ADDR  = ADDR_W'(DEFAULT_FETCH_ADDR),
  parameter logic [ADDR_W-1:0] UNDEF_CODE  = ADDR_W'(DEFAULT_UNDEF_CODE),
  parameter int                MFC_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] encoder_IN,
  input  logic [2:0]        ns_sel,
  input  logic [ADDR_W-1:0] cr_addr,
  input  logic              inv,
  input  logic              cond_IN,
  input  logic              mfc,
  output logic [ADDR_W-1:0] state_OUT,
  output logic              wait_OUT,
  output logic              timeout_OUT,
  output logic              undef_OUT
);

  localparam int CNT_W = $clog2(MFC_TIMEOUT + 1);

  seqState_t         seqState, nextSeqState;
  logic [ADDR_W-1:0] stateAddr, nextAddr;
  logic [ADDR_W-1:0] retAddr, nextRetAddr;
  logic              retValid, nextRetValid;
  logic [CNT_W-1:0]  waitCnt, nextWaitCnt;
  logic              timeoutPulse, nextTimeout;
  logic              undefPulse, nextUndef;
  logic [ADDR_W-1:0] incAddr, runAddr;

  microseq_nextaddr_mux #(
    .ADDR_W    (ADDR_W),
    .FETCH_ADDR(FETCH_ADDR)
  ) u_mux (
    .state      (stateAddr),
    .nsSel      (ns_sel),
    .crAddr     (cr_addr),
    .encoderAddr(encoder_IN),
    .inv        (inv),
    .cond       (cond_IN),
    .mfc        (mfc),
    .retAddr    (retAddr),
    .retValid   (retValid),
    .incAddr    (incAddr),
    .runAddr    (runAddr)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      seqState     <= RUN;
      stateAddr    <= '0;
      retAddr      <= '0;
      retValid     <= 1'b0;
      waitCnt      <= '0;
      timeoutPulse <= 1'b0;
      undefPulse   <= 1'b0;
    end else begin
      seqState     <= nextSeqState;
      stateAddr    <= nextAddr;
      retAddr      <= nextRetAddr;
      retValid     <= nextRetValid;
      waitCnt      <= nextWaitCnt;
      timeoutPulse <= nextTimeout;
      undefPulse   <= nextUndef;
    end
  end

  // In WAIT a late MFC beats the timeout, and the counter stops at MFC_TIMEOUT so it never wraps.
  always_comb begin
    nextSeqState = seqState;
    nextAddr     = stateAddr;
    nextRetAddr  = retAddr;
    nextRetValid = retValid;
    nextWaitCnt  = waitCnt;
    nextTimeout  = 1'b0;
    nextUndef    = 1'b0;
    case (seqState)
      RUN: begin
        nextAddr = runAddr;
        case (ns_sel)
          NS_DECODE: nextUndef = (encoder_IN == UNDEF_CODE);
          NS_WAITMFC: begin
            if (!mfc) begin
              nextSeqState = WAIT;
              nextWaitCnt  = CNT_W'(1);
            end
          end
          NS_CALL: begin
            nextRetAddr  = incAddr;
            nextRetValid = 1'b1;
          end
          NS_RET: nextRetValid = 1'b0;
          default: ;
        endcase
      end
      WAIT: begin
        if (mfc) begin
          nextAddr     = incAddr;
          nextSeqState = RUN;
          nextWaitCnt  = '0;
        end else if (waitCnt == CNT_W'(MFC_TIMEOUT)) begin
          nextAddr     = FETCH_ADDR;
          nextTimeout  = 1'b1;
          nextSeqState = RUN;
          nextWaitCnt  = '0;
        end else begin
          nextWaitCnt = waitCnt + CNT_W'(1);
        end
      end
      default: nextSeqState = RUN;
    endcase
  end

  assign state_OUT   = stateAddr;
  assign wait_OUT    = (seqState == WAIT);
  assign timeout_OUT = timeoutPulse;
  assign undef_OUT   = undefPulse;

endmodule

// File: tb/tb_microseq_controller.sv
// Scoreboard bench for microseq_controller: each stimulus cycle queues the expected
// address and flags, which are popped and compared after the following clock edge.
module tb_microseq_controller;
  import microseq_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] encoderIn = '0;
  logic [2:0] nsSel = '0;
  logic [6:0] crAddr = '0;
  logic       inv = 1'b0;
  logic       condIn = 1'b0;
  logic       mfc = 1'b0;
  logic [6:0] stateOut;
  logic       waitOut, timeoutOut, undefOut;

  typedef struct {
    string      tag;
    logic [6:0] st;
    logic       w;
    logic       to;
    logic       un;
  } expect_t;

  expect_t sbQ[$];
  int checkCount = 0;
  int errorCount = 0;

  microseq_controller #(
    .ADDR_W(7), .FETCH_ADDR(7'd1), .UNDEF_CODE(7'd91), .MFC_TIMEOUT(15)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .encoder_IN (encoderIn),
    .ns_sel     (nsSel),
    .cr_addr    (crAddr),
    .inv        (inv),
    .cond_IN    (condIn),
    .mfc        (mfc),
    .state_OUT  (stateOut),
    .wait_OUT   (waitOut),
    .timeout_OUT(timeoutOut),
    .undef_OUT  (undefOut)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int unsigned observed, input int unsigned expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic compareNext();
    expect_t e;
    if (sbQ.size() == 0) begin
      checkOutput("scoreboard.empty", 1, 0);
      return;
    end
    e = sbQ.pop_front();
    checkOutput({e.tag, ".state"},   stateOut,   e.st);
    checkOutput({e.tag, ".wait"},    waitOut,    e.w);
    checkOutput({e.tag, ".timeout"}, timeoutOut, e.to);
    checkOutput({e.tag, ".undef"},   undefOut,   e.un);
  endtask

  // Drive one microinstruction cycle, queue its expected result, then clock and compare.
  task automatic applyStimulus(input string tag, input logic rst, input logic [2:0] ns,
                               input logic [6:0] cr, input logic [6:0] enc, input logic iv,
                               input logic cd, input logic mf, input logic [6:0] eSt,
                               input logic eW, input logic eTo, input logic eUn);
    expect_t e;
    reset = rst; nsSel = ns; crAddr = cr; encoderIn = enc; inv = iv; condIn = cd; mfc = mf;
    e.tag = tag; e.st = eSt; e.w = eW; e.to = eTo; e.un = eUn;
    sbQ.push_back(e);
    @(posedge clk);
    #1;
    compareNext();
  endtask

  task automatic jumpTo(input logic [6:0] addr);
    applyStimulus("jump", 0, NS_JUMP, addr, 0, 0, 0, 0, addr, 0, 0, 0);
  endtask

  initial begin
    #1;
    applyStimulus("reset", 1, NS_JUMP, 7'd99, 0, 0, 0, 0, 7'd0, 0, 0, 0);

    applyStimulus("inc1", 0, NS_INC, 0, 0, 0, 0, 0, 7'd1, 0, 0, 0);
    applyStimulus("inc2", 0, NS_INC, 0, 0, 0, 0, 0, 7'd2, 0, 0, 0);
    applyStimulus("inc3", 0, NS_INC, 0, 0, 0, 0, 0, 7'd3, 0, 0, 0);
    jumpTo(7'd127);
    applyStimulus("incWrap", 0, NS_INC, 0, 0, 0, 0, 0, 7'd0, 0, 0, 0);

    applyStimulus("decode43", 0, NS_DECODE, 0, 7'd43, 0, 0, 0, 7'd43, 0, 0, 0);
    applyStimulus("decodeUndef", 0, NS_DECODE, 0, 7'd91, 0, 0, 0, 7'd91, 0, 0, 1);
    applyStimulus("undefDrop", 0, NS_INC, 0, 0, 0, 0, 0, 7'd92, 0, 0, 0);
    applyStimulus("decodeZero", 0, NS_DECODE, 7'd33, 7'd0, 0, 0, 0, 7'd0, 0, 0, 0);

    jumpTo(7'd20);
    applyStimulus("condC1I0", 0, NS_COND, 7'd50, 0, 0, 1, 0, 7'd50, 0, 0, 0);
    jumpTo(7'd20);
    applyStimulus("condC1I1", 0, NS_COND, 7'd50, 0, 1, 1, 0, 7'd21, 0, 0, 0);
    jumpTo(7'd20);
    applyStimulus("condC0I1", 0, NS_COND, 7'd50, 0, 1, 0, 0, 7'd50, 0, 0, 0);
    jumpTo(7'd20);
    applyStimulus("condC0I0", 0, NS_COND, 7'd50, 0, 0, 0, 0, 7'd21, 0, 0, 0);
    applyStimulus("fetch", 0, NS_FETCH, 7'd77, 0, 0, 0, 0, 7'd1, 0, 0, 0);

    // MFC arrives in the fourth stalled cycle; ns_sel/cr_addr are junk and must be ignored.
    jumpTo(7'd10);
    applyStimulus("waitEnter", 0, NS_WAITMFC, 0, 0, 0, 0, 0, 7'd10, 1, 0, 0);
    for (int i = 0; i < 3; i++)
      applyStimulus("waitHold", 0, NS_JUMP, 7'd99, 7'd5, 0, 0, 0, 7'd10, 1, 0, 0);
    applyStimulus("waitMfc", 0, NS_JUMP, 7'd99, 0, 0, 0, 1, 7'd11, 0, 0, 0);

    jumpTo(7'd10);
    applyStimulus("waitSameCycle", 0, NS_WAITMFC, 0, 0, 0, 0, 1, 7'd11, 0, 0, 0);

    jumpTo(7'd10);
    applyStimulus("toEnter", 0, NS_WAITMFC, 0, 0, 0, 0, 0, 7'd10, 1, 0, 0);
    for (int i = 0; i < 14; i++)
      applyStimulus("toHold", 0, NS_INC, 0, 0, 0, 0, 0, 7'd10, 1, 0, 0);
    applyStimulus("toFire", 0, NS_INC, 0, 0, 0, 0, 0, 7'd1, 0, 1, 0);
    applyStimulus("toDrop", 0, NS_INC, 0, 0, 0, 0, 0, 7'd2, 0, 0, 0);

    jumpTo(7'd10);
    applyStimulus("lateEnter", 0, NS_WAITMFC, 0, 0, 0, 0, 0, 7'd10, 1, 0, 0);
    for (int i = 0; i < 14; i++)
      applyStimulus("lateHold", 0, NS_INC, 0, 0, 0, 0, 0, 7'd10, 1, 0, 0);
    applyStimulus("lateMfc", 0, NS_INC, 0, 0, 0, 0, 1, 7'd11, 0, 0, 0);

    jumpTo(7'd10);
    applyStimulus("rstEnter", 0, NS_WAITMFC, 0, 0, 0, 0, 0, 7'd10, 1, 0, 0);
    for (int i = 0; i < 4; i++)
      applyStimulus("rstHold", 0, NS_INC, 0, 0, 0, 0, 0, 7'd10, 1, 0, 0);
    applyStimulus("rstInWait", 1, NS_INC, 0, 0, 0, 0, 0, 7'd0, 0, 0, 0);
    applyStimulus("rstAfter", 0, NS_INC, 0, 0, 0, 0, 0, 7'd1, 0, 0, 0);

    jumpTo(7'd30);
    applyStimulus("call", 0, NS_CALL, 7'd60, 0, 0, 0, 0, 7'd60, 0, 0, 0);
    applyStimulus("ret", 0, NS_RET, 7'd99, 0, 0, 0, 0, 7'd31, 0, 0, 0);
    applyStimulus("retEmpty", 0, NS_RET, 7'd99, 0, 0, 0, 0, 7'd1, 0, 0, 0);

    jumpTo(7'd30);
    applyStimulus("callOuter", 0, NS_CALL, 7'd60, 0, 0, 0, 0, 7'd60, 0, 0, 0);
    applyStimulus("callNested", 0, NS_CALL, 7'd70, 0, 0, 0, 0, 7'd70, 0, 0, 0);
    applyStimulus("retNested", 0, NS_RET, 0, 0, 0, 0, 0, 7'd61, 0, 0, 0);
    applyStimulus("retNestedEmpty", 0, NS_RET, 0, 0, 0, 0, 0, 7'd1, 0, 0, 0);

    checkOutput("scoreboard.drained", sbQ.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
